roc_decoder: RTL and testbench
==============================

ROC_DECODER -- requirements
Module: roc_decoder

Interface
REQ-001 Parameters SHALL be:
- IMAGE_SIZE, default 7: number of pixels.
- PIXEL_MAX_VALUE, default 255: value given to rank 0.
- IDX_BITS, default $clog2(IMAGE_SIZE): address width.
- PIXEL_BITS, default $clog2(PIXEL_MAX_VALUE+1): pixel width.
REQ-002 CLK  input  1  single clock, all state rising-edge.
REQ-003 RST_N  input  1  asynchronous active-low reset.
REQ-004 START  input  1  one-cycle pulse; clears the image and begins a new decode.
REQ-005 AERIN_REQ  input  1  4-phase request, synchronous to CLK.
REQ-006 AERIN_ADDR  input  IDX_BITS  spike index, valid while AERIN_REQ=1.
REQ-007 AERIN_ACK  output  1  4-phase acknowledge.
REQ-008 IMAGE  output  [PIXEL_BITS-1:0] x IMAGE_SIZE  reconstructed image.
REQ-009 DECODER_BUSY  output  1  high in WAIT_REQ and ACK states.
REQ-010 DECODE_DONE  output  1  level; all IMAGE_SIZE distinct indices received.
REQ-011 DUP_ERR  output  1  sticky; a duplicate index was received since the last START.
REQ-012 ADDR_ERR  output  1  sticky; an index >= IMAGE_SIZE was received since the last START.

Function
REQ-013 FSM states SHALL be IDLE, WAIT_REQ, ACK and DONE.
REQ-014 IDLE SHALL move to WAIT_REQ on START; AERIN_REQ in IDLE SHALL be ignored, with no ACK.
REQ-015 On START, in the same edge, the block SHALL:
- clear every IMAGE word, the valid bitmap, the rank counter, DUP_ERR, ADDR_ERR and DECODE_DONE;
- enter WAIT_REQ.
REQ-016 In WAIT_REQ, AERIN_REQ=1 at an edge SHALL capture AERIN_ADDR, update state per REQ-017..019, set AERIN_ACK=1 and enter ACK, all at that edge (one-cycle latency REQ-to-ACK).
REQ-017 For a valid, unwritten index, the block SHALL:
- write IMAGE[addr] = PIXEL_MAX_VALUE - rank, saturating at 0 when rank > PIXEL_MAX_VALUE;
- set valid[addr];
- increment rank.
REQ-018 A duplicate index (valid[addr]=1) SHALL leave IMAGE and rank unchanged and set DUP_ERR.
REQ-019 An index >= IMAGE_SIZE SHALL leave IMAGE and rank unchanged and set ADDR_ERR.
REQ-020 In ACK, AERIN_ACK SHALL stay 1 until AERIN_REQ=0 is sampled; at that edge AERIN_ACK SHALL go to 0.
REQ-021 On leaving ACK, the next state SHALL be DONE if rank==IMAGE_SIZE, else WAIT_REQ.
REQ-022 DONE SHALL hold DECODE_DONE=1 and keep IMAGE stable; requests in DONE SHALL be ignored, with no ACK.
REQ-023 START in DONE SHALL behave per REQ-015.
REQ-024 START in WAIT_REQ or ACK SHALL abort the decode and behave per REQ-015, with AERIN_ACK forced to 0; START has priority over a simultaneous REQ.
REQ-025 The rank counter width SHALL be $clog2(IMAGE_SIZE+1); rank SHALL never exceed IMAGE_SIZE.
REQ-026 Pixels never addressed SHALL read 0.

Reset
REQ-027 RST_N=0 SHALL asynchronously force:
- state IDLE;
- AERIN_ACK=0, DECODER_BUSY=0, DECODE_DONE=0, DUP_ERR=0, ADDR_ERR=0;
- all IMAGE words to 0, valid bitmap to 0, rank to 0.
REQ-028 Reset deassertion SHALL be synchronised internally; the first active edge after RST_N rises SHALL see the block in IDLE.
REQ-029 Reset mid-handshake SHALL drop AERIN_ACK immediately, without waiting for a clock edge.

Verification
REQ-030 Full decode: START, then addresses 3,0,6,1,5,2,4 with a full 4-phase handshake each -> IMAGE = {254,252,250,255,249,251,253}, DECODE_DONE=1 after the 7th ACK falls, no errors.
REQ-031 Duplicate: START, then 2,2,... -> second ACK returned, IMAGE[2]=255 kept, DUP_ERR=1, DECODE_DONE only after 7 distinct indices.
REQ-032 Bad address: START, then address 7 -> ACK returned, ADDR_ERR=1, IMAGE all 0, rank 0.
REQ-033 Handshake timing: REQ held high 5 cycles -> ACK rises 1 edge after REQ is sampled, stays high while REQ=1, falls at the edge sampling REQ=0; a single REQ yields exactly one write.
REQ-034 Abort: START during ACK after 3 events -> ACK=0 next edge, IMAGE cleared, the next event is written as 255.
REQ-035 Async reset: RST_N pulsed low between clock edges mid-decode -> ACK and all outputs 0 before the next edge; REQ ignored until START.

Source files
------------

// File: rtl/roc_decoder.sv
`default_nettype none
// ============================================================================
// Module      : roc_decoder
// Description : Rank-order-code decoder. Spike indices arrive over a 4-phase
//               AER handshake; the n-th distinct index received gets pixel
//               value PIXEL_MAX_VALUE - n (saturating at 0). Duplicate and
//               out-of-range indices are acknowledged but only flag sticky
//               errors.
// Ports       : clk_i            - clock, all state on rising edge
//               rst_ni           - asynchronous active-low reset
//               start_i          - one-cycle pulse, clears image, starts decode
//               aerin_req_i      - 4-phase request
//               aerin_addr_i     - spike index, valid while request is high
//               aerin_ack_o      - 4-phase acknowledge
//               image_o          - packed image, word i at [i*PIXEL_BITS +: PIXEL_BITS]
//               decoder_busy_o   - high while waiting for / acknowledging events
//               decode_done_o    - all IMAGE_SIZE distinct indices received
//               dup_err_o        - sticky duplicate-index flag
//               addr_err_o       - sticky out-of-range-index flag
// Revision    : 1.0 - initial release
// ============================================================================
module roc_decoder #(
  parameter int IMAGE_SIZE      = 7,
  parameter int PIXEL_MAX_VALUE = 255,
  parameter int IDX_BITS        = $clog2(IMAGE_SIZE),
  parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               start_i,
  input  logic                               aerin_req_i,
  input  logic [IDX_BITS-1:0]                aerin_addr_i,
  output logic                               aerin_ack_o,
  output logic [IMAGE_SIZE*PIXEL_BITS-1:0]   image_o,
  output logic                               decoder_busy_o,
  output logic                               decode_done_o,
  output logic                               dup_err_o,
  output logic                               addr_err_o
);

  localparam int RANK_BITS = $clog2(IMAGE_SIZE + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_REQ = 2'd1,
    S_ACK      = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  // Reset synchroniser: assertion is asynchronous so the handshake drops
  // immediately, release is aligned to the clock so every flop leaves reset
  // on the same edge.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync_q[1];

  state_t                  state_q;
  logic                    ack_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    dup_q;
  logic                    aerr_q;
  logic [IMAGE_SIZE-1:0]   valid_q;
  logic [RANK_BITS-1:0]    rank_q;
  logic [PIXEL_BITS-1:0]   img_q [IMAGE_SIZE];

  logic [IMAGE_SIZE-1:0]   addr_oh;
  logic                    addr_bad;
  logic                    addr_dup;
  logic [PIXEL_BITS-1:0]   pix_d;

  // One-hot decode of the incoming index; an out-of-range index decodes to
  // all zeros so it can never touch the image or the bitmap.
  always_comb begin
    addr_oh = '0;
    for (int i = 0; i < IMAGE_SIZE; i++) begin
      addr_oh[i] = (32'(aerin_addr_i) == 32'(i));
    end
  end

  assign addr_bad = (32'(aerin_addr_i) >= 32'(IMAGE_SIZE));
  assign addr_dup = |(addr_oh & valid_q);

  // Pixel value for the next new index; clamps at 0 once the rank passes
  // the maximum pixel value.
  always_comb begin
    if (32'(rank_q) > 32'(PIXEL_MAX_VALUE)) begin
      pix_d = '0;
    end else begin
      pix_d = PIXEL_BITS'(32'(PIXEL_MAX_VALUE) - 32'(rank_q));
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dup_q   <= 1'b0;
      aerr_q  <= 1'b0;
      valid_q <= '0;
      rank_q  <= '0;
      for (int i = 0; i < IMAGE_SIZE; i++) begin
        img_q[i] <= '0;
      end
    end else if (start_i) begin
      // START wins over everything, including a request in the same cycle.
      state_q <= S_WAIT_REQ;
      ack_q   <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      dup_q   <= 1'b0;
      aerr_q  <= 1'b0;
      valid_q <= '0;
      rank_q  <= '0;
      for (int i = 0; i < IMAGE_SIZE; i++) begin
        img_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_WAIT_REQ: begin
          if (aerin_req_i) begin
            state_q <= S_ACK;
            ack_q   <= 1'b1;
            if (addr_bad) begin
              aerr_q <= 1'b1;
            end else if (addr_dup) begin
              dup_q <= 1'b1;
            end else begin
              for (int i = 0; i < IMAGE_SIZE; i++) begin
                if (addr_oh[i]) begin
                  img_q[i] <= pix_d;
                end
              end
              valid_q <= valid_q | addr_oh;
              rank_q  <= rank_q + RANK_BITS'(1);
            end
          end
        end
        S_ACK: begin
          if (!aerin_req_i) begin
            ack_q <= 1'b0;
            if (rank_q == RANK_BITS'(IMAGE_SIZE)) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_WAIT_REQ;
            end
          end
        end
        default: begin
          // IDLE and DONE ignore requests and hold the image.
          state_q <= state_q;
        end
      endcase
    end
  end

  for (genvar g = 0; g < IMAGE_SIZE; g++) begin : g_img
    assign image_o[g*PIXEL_BITS +: PIXEL_BITS] = img_q[g];
  end

  assign aerin_ack_o    = ack_q;
  assign decoder_busy_o = busy_q;
  assign decode_done_o  = done_q;
  assign dup_err_o      = dup_q;
  assign addr_err_o     = aerr_q;

endmodule
`default_nettype wire

// File: tb/tb_roc_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_roc_decoder
// Description : Self-checking bench for roc_decoder. The stimulus side keeps a
//               small model of the image and pushes the expected state for
//               every acknowledge and for the decode-done rise; a monitor
//               pops and compares when the DUT presents those events.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_roc_decoder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        req;
  logic [2:0]  addr;
  logic        ack;
  logic [55:0] image;
  logic        busy;
  logic        done;
  logic        dup;
  logic        aerr;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          is_done;
    logic [55:0] img;
    bit          dup;
    bit          aerr;
  } exp_t;

  exp_t q[$];

  int m_img [7];
  bit m_valid [7];
  int m_rank;
  bit m_dup;
  bit m_aerr;

  roc_decoder dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .aerin_req_i    (req),
    .aerin_addr_i   (addr),
    .aerin_ack_o    (ack),
    .image_o        (image),
    .decoder_busy_o (busy),
    .decode_done_o  (done),
    .dup_err_o      (dup),
    .addr_err_o     (aerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [55:0] pack_model();
    logic [55:0] v;
    v = '0;
    for (int i = 0; i < 7; i++) v[i*8 +: 8] = 8'(m_img[i]);
    return v;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 7; i++) begin
      m_img[i]   = 0;
      m_valid[i] = 1'b0;
    end
    m_rank = 0;
    m_dup  = 1'b0;
    m_aerr = 1'b0;
  endtask

  // Raise a request, update the model, queue the expectations, check latency.
  task automatic req_up(input int a);
    exp_t e;
    bit   wrote;
    @(posedge clk); #1;
    addr  = 3'(a);
    req   = 1'b1;
    wrote = 1'b0;
    if (a >= 7) m_aerr = 1'b1;
    else if (m_valid[a]) m_dup = 1'b1;
    else begin
      m_img[a]   = (m_rank > 255) ? 0 : 255 - m_rank;
      m_valid[a] = 1'b1;
      m_rank++;
      wrote = 1'b1;
    end
    e.is_done = 1'b0;
    e.img     = pack_model();
    e.dup     = m_dup;
    e.aerr    = m_aerr;
    q.push_back(e);
    if (wrote && m_rank == 7) begin
      e.is_done = 1'b1;
      q.push_back(e);
    end
    @(posedge clk); #1;
    chk("ack_rise", {63'd0, ack}, 64'd1);
  endtask

  task automatic req_down();
    req = 1'b0;
    @(posedge clk); #1;
    chk("ack_fall", {63'd0, ack}, 64'd0);
  endtask

  task automatic hs(input int a, input int hold);
    req_up(a);
    for (int k = 1; k < hold; k++) begin
      @(posedge clk); #1;
      chk("ack_hold", {63'd0, ack}, 64'd1);
    end
    req_down();
  endtask

  // A request that must be ignored (IDLE / DONE / after reset).
  task automatic ignored_req(input int a, input int n, input string name);
    @(posedge clk); #1;
    addr = 3'(a);
    req  = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      chk(name, {63'd0, ack}, 64'd0);
    end
    req = 1'b0;
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_clear();
    chk("start_image", 64'(image), 64'd0);
    chk("start_done",  {63'd0, done}, 64'd0);
    chk("start_errs",  {62'd0, dup, aerr}, 64'd0);
    chk("start_busy",  {63'd0, busy}, 64'd1);
  endtask

  task automatic sb_compare(input string tag, input bit is_done);
    exp_t e;
    if (q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL sb_%s: unexpected output event, nothing expected (t=%0t)", tag, $time);
    end else begin
      e = q.pop_front();
      chk({"sb_", tag, "_kind"},  {63'd0, is_done}, {63'd0, e.is_done});
      chk({"sb_", tag, "_image"}, 64'(image), 64'(e.img));
      chk({"sb_", tag, "_dup"},   {63'd0, dup}, {63'd0, e.dup});
      chk({"sb_", tag, "_aerr"},  {63'd0, aerr}, {63'd0, e.aerr});
      chk({"sb_", tag, "_busy"},  {63'd0, busy}, {63'd0, !e.is_done});
      chk({"sb_", tag, "_done"},  {63'd0, done}, {63'd0, e.is_done});
    end
  endtask

  // Monitor: compare on every acknowledge rise and every decode-done rise.
  logic prev_ack  = 1'b0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (ack === 1'b1 && prev_ack !== 1'b1) sb_compare("ack", 1'b0);
    if (done === 1'b1 && prev_done !== 1'b1) sb_compare("done", 1'b1);
    prev_ack  <= ack;
    prev_done <= done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq_full [7];
    int seq_dup  [7];
    seq_full = '{3, 0, 6, 1, 5, 2, 4};
    seq_dup  = '{2, 2, 0, 1, 3, 4, 5};
    rst_n = 1'b0;
    start = 1'b0;
    req   = 1'b0;
    addr  = '0;
    m_clear();

    // Reset state
    #12;
    chk("rst_ack",   {63'd0, ack}, 64'd0);
    chk("rst_busy",  {63'd0, busy}, 64'd0);
    chk("rst_done",  {63'd0, done}, 64'd0);
    chk("rst_errs",  {62'd0, dup, aerr}, 64'd0);
    chk("rst_image", 64'(image), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Requests in IDLE are ignored
    ignored_req(1, 3, "idle_no_ack");
    chk("idle_image", 64'(image), 64'd0);

    // Full decode; first event held 5 cycles to exercise handshake timing
    do_start();
    for (int i = 0; i < 7; i++) hs(seq_full[i], (i == 0) ? 5 : 1);
    chk("full_image", 64'(image), 64'h00FDFBF9FFFAFCFE);
    chk("full_done",  {63'd0, done}, 64'd1);
    chk("full_errs",  {62'd0, dup, aerr}, 64'd0);
    chk("full_busy",  {63'd0, busy}, 64'd0);
    ignored_req(0, 2, "done_no_ack");
    chk("done_image_stable", 64'(image), 64'h00FDFBF9FFFAFCFE);

    // Duplicate index
    do_start();
    for (int i = 0; i < 7; i++) hs(seq_dup[i], 1);
    chk("dup_flag",     {63'd0, dup}, 64'd1);
    chk("dup_pix2",     64'(image[23:16]), 64'hFF);
    chk("dup_not_done", {63'd0, done}, 64'd0);
    hs(6, 1);
    chk("dup_done",  {63'd0, done}, 64'd1);
    chk("dup_image", 64'(image), 64'h00F9FAFBFCFFFDFE);

    // Out-of-range index
    do_start();
    hs(7, 1);
    chk("aerr_flag",  {63'd0, aerr}, 64'd1);
    chk("aerr_image", 64'(image), 64'd0);
    hs(1, 1);
    chk("aerr_rank0", 64'(image), 64'h000000000000FF00);

    // Abort during ACK after three events; START collides with REQ high
    do_start();
    hs(0, 1);
    hs(1, 1);
    hs(2, 1);
    req_up(3);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    req   = 1'b0;
    m_clear();
    chk("abort_ack",   {63'd0, ack}, 64'd0);
    chk("abort_image", 64'(image), 64'd0);
    chk("abort_busy",  {63'd0, busy}, 64'd1);
    hs(5, 1);
    chk("abort_next", 64'(image), 64'h0000FF0000000000);

    // Asynchronous reset mid-handshake
    do_start();
    hs(4, 1);
    req_up(5);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ack",   {63'd0, ack}, 64'd0);
    chk("arst_busy",  {63'd0, busy}, 64'd0);
    chk("arst_done",  {63'd0, done}, 64'd0);
    chk("arst_errs",  {62'd0, dup, aerr}, 64'd0);
    chk("arst_image", 64'(image), 64'd0);
    #1;
    rst_n = 1'b1;
    m_clear();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("arst_req_ignored", {63'd0, ack}, 64'd0);
    end
    req = 1'b0;
    do_start();
    hs(6, 1);
    chk("arst_restart", 64'(image), 64'h00FF000000000000);

    repeat (3) @(posedge clk);
    chk("sb_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
